// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner: walks the CPU register-inspection port from FIRST_REG to
// LAST_REG, lets each selection settle, samples val, and streams
// (index, value) pairs over a valid/ready handshake with a running checksum.
module reg_dump_scanner #(
  parameter int unsigned FIRST_REG     = 0,
  parameter int unsigned LAST_REG      = 31,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        startin,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] val,
  input  logic        out_ready,
  output logic [4:0]  regNo,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_OUT
  } state_t;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);
  localparam logic [3:0] CNT_INIT  = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  reg_no_d;
  logic        out_valid_d;
  logic [31:0] out_data_d;
  logic [4:0]  out_index_d;
  logic        busy_d;
  logic        done_d;
  logic [31:0] checksum_d;

  // Next-state and next-output computation; every register defaults to hold.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reg_no_d    = regNo;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_index_d = out_index;
    done_d      = done;
    checksum_d  = checksum;

    case (state_q)
      S_IDLE: begin
        reg_no_d    = FIRST_IDX;
        out_valid_d = 1'b0;
        if (start) begin
          cnt_d      = CNT_INIT;
          checksum_d = '0;
          done_d     = 1'b0;
          state_d    = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          out_valid_d = 1'b0;
          reg_no_d    = FIRST_IDX;
          state_d     = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_data_d  = val;
          out_index_d = regNo;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end

      S_OUT: begin
        // Abort wins over a same-cycle handshake, so the word is never summed.
        if (abort) begin
          out_valid_d = 1'b0;
          reg_no_d    = FIRST_IDX;
          state_d     = S_IDLE;
        end else if (out_ready) begin
          checksum_d  = checksum + out_data;
          out_valid_d = 1'b0;
          if (regNo == LAST_IDX) begin
            done_d   = 1'b1;
            reg_no_d = FIRST_IDX;
            state_d  = S_IDLE;
          end else begin
            reg_no_d = regNo + 5'd1;
            cnt_d    = CNT_INIT;
            state_d  = S_SETTLE;
          end
        end
      end

      default: begin
        out_valid_d = 1'b0;
        reg_no_d    = FIRST_IDX;
        state_d     = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (startin) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      regNo     <= FIRST_IDX;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      regNo     <= reg_no_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_index <= out_index_d;
      busy      <= busy_d;
      done      <= done_d;
      checksum  <= checksum_d;
    end
  end

  // Last-word flag decoded from registered values only.
  always_comb begin
    out_last = out_valid && (out_index == LAST_IDX);
  end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Self-checking bench for reg_dump_scanner: table-driven full dumps, directed
// multi-cycle corner cases, and randomized backpressure against a simple
// register-file model.
`timescale 1ns/1ps
module tb_reg_dump_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, abort0, ready0;
  logic [31:0] val0, out_data0, checksum0;
  logic [4:0]  reg_no0, out_index0;
  logic        out_valid0, out_last0, busy0, done0;

  logic        start1, abort1, ready1;
  logic [31:0] val1, out_data1, checksum1;
  logic [4:0]  reg_no1, out_index1;
  logic        out_valid1, out_last1, busy1, done1;

  // CPU register file model seen through the inspection port.
  logic [31:0] rf [32];
  assign val0 = rf[reg_no0];
  assign val1 = rf[reg_no1];

  reg_dump_scanner #(.FIRST_REG(0), .LAST_REG(31), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .startin(rst), .start(start0), .abort(abort0), .val(val0),
    .out_ready(ready0), .regNo(reg_no0), .out_valid(out_valid0),
    .out_data(out_data0), .out_index(out_index0), .out_last(out_last0),
    .busy(busy0), .done(done0), .checksum(checksum0)
  );

  reg_dump_scanner #(.FIRST_REG(8), .LAST_REG(10), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .startin(rst), .start(start1), .abort(abort1), .val(val1),
    .out_ready(ready1), .regNo(reg_no1), .out_valid(out_valid1),
    .out_data(out_data1), .out_index(out_index1), .out_last(out_last1),
    .busy(busy1), .done(done1), .checksum(checksum1)
  );

  int errors = 0;
  int checks = 0;

  logic [4:0]  q0_idx[$];
  logic [31:0] q0_data[$];
  logic [4:0]  q1_idx[$];
  logic [31:0] q1_data[$];

  typedef struct {
    logic [31:0] mul;
    logic [31:0] add;
    logic [31:0] exp_sum;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_sum(input int first, input int last);
    logic [31:0] s = '0;
    for (int i = first; i <= last; i++) s = s + rf[i];
    return s;
  endfunction

  // Record accepted words and check the last-word flag away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid0 && ready0 && !abort0) begin
        q0_idx.push_back(out_index0);
        q0_data.push_back(out_data0);
      end
      if (out_valid1 && ready1 && !abort1) begin
        q1_idx.push_back(out_index1);
        q1_data.push_back(out_data1);
      end
      if (out_valid0) check("out_last0", 32'(out_last0), 32'(out_index0 == 5'd31));
      else if (out_last0) check("out_last0_idle", 32'(out_last0), 32'd0);
      if (out_valid1) check("out_last1", 32'(out_last1), 32'(out_index1 == 5'd10));
    end
  end

  task automatic verify_words0(input int first, input int last);
    int n = last - first + 1;
    check("word_count0", q0_idx.size(), n);
    for (int i = 0; i < n && i < q0_idx.size(); i++) begin
      check("word_idx0", q0_idx[i], first + i);
      check("word_data0", q0_data[i], rf[first + i]);
    end
  endtask

  task automatic pulse_start0();
    q0_idx.delete();
    q0_data.delete();
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  task automatic run_dump0(input bit rnd, input int limit, output int cyc);
    pulse_start0();
    check("busy_after_start", 32'(busy0), 32'd1);
    check("regno_after_start", reg_no0, 32'd0);
    cyc = 0;
    while (!done0 && cyc < limit) begin
      if (rnd) ready0 = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    ready0 = 1'b1;
    check("dump_done", 32'(done0), 32'd1);
    check("dump_busy_clear", 32'(busy0), 32'd0);
  endtask

  task automatic wait_done0(input int limit, inout int cyc);
    while (!done0 && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("wait_done0", 32'(done0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt [6];
    int cyc;
    int first_valid;
    int cnt4;

    vt[0] = '{mul: 32'd3,          add: 32'd0,          exp_sum: 32'd1488};
    vt[1] = '{mul: 32'd1,          add: 32'd0,          exp_sum: 32'd496};
    vt[2] = '{mul: 32'd0,          add: 32'd7,          exp_sum: 32'd224};
    vt[3] = '{mul: 32'hFFFFFFFF,   add: 32'd0,          exp_sum: 32'hFFFFFE10};
    vt[4] = '{mul: 32'd2,          add: 32'd5,          exp_sum: 32'd1152};
    vt[5] = '{mul: 32'h10000000,   add: 32'h80000000,   exp_sum: 32'd0};

    rst = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
    for (int n = 0; n < 32; n++) rf[n] = 32'(3 * n);
    repeat (2) @(posedge clk);
    #1;
    check("rst_regno", reg_no0, 32'd0);
    check("rst_valid", 32'(out_valid0), 32'd0);
    check("rst_data", out_data0, 32'd0);
    check("rst_index", out_index0, 32'd0);
    check("rst_last", 32'(out_last0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_checksum", checksum0, 32'd0);
    check("rst_regno1", reg_no1, 32'd8);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven full dumps with ready held high.
    for (int v = 0; v < 6; v++) begin
      for (int n = 0; n < 32; n++) rf[n] = vt[v].mul * 32'(n) + vt[v].add;
      run_dump0(1'b0, 200, cyc);
      check("tbl_cycles", cyc, 32'd64);
      check("tbl_checksum", checksum0, vt[v].exp_sum);
      check("tbl_model_sum", checksum0, model_sum(0, 31));
      verify_words0(0, 31);
      @(posedge clk); #1;
    end

    for (int n = 0; n < 32; n++) rf[n] = 32'(3 * n);

    // Backpressure on index 4.
    pulse_start0();
    cyc = 0;
    while (reg_no0 != 5'd4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_reach_idx4", reg_no0, 32'd4);
    ready0 = 1'b0;
    @(posedge clk); #1;
    check("bp_valid", 32'(out_valid0), 32'd1);
    check("bp_index", out_index0, 32'd4);
    check("bp_data", out_data0, 32'd12);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid0), 32'd1);
      check("bp_hold_index", out_index0, 32'd4);
      check("bp_hold_data", out_data0, 32'd12);
      check("bp_hold_regno", reg_no0, 32'd4);
    end
    check("bp_checksum_frozen", checksum0, model_sum(0, 3));
    ready0 = 1'b1;
    cyc = 0;
    wait_done0(200, cyc);
    check("bp_checksum", checksum0, 32'd1488);
    cnt4 = 0;
    foreach (q0_idx[i]) if (q0_idx[i] == 5'd4) cnt4++;
    check("bp_idx4_once", cnt4, 32'd1);
    verify_words0(0, 31);

    // Partial range on the second instance.
    @(posedge clk); #1;
    q1_idx.delete();
    q1_data.delete();
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("part_regno_start", reg_no1, 32'd8);
    cyc = 0;
    first_valid = -1;
    while (!done1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid1 && first_valid < 0) first_valid = cyc;
    end
    check("part_first_valid", first_valid, 32'd3);
    check("part_cycles", cyc, 32'd12);
    check("part_count", q1_idx.size(), 32'd3);
    for (int i = 0; i < 3 && i < q1_idx.size(); i++) begin
      check("part_idx", q1_idx[i], 32'(8 + i));
      check("part_data", q1_data[i], rf[8 + i]);
    end
    check("part_checksum", checksum1, model_sum(8, 10));
    check("part_busy", 32'(busy1), 32'd0);

    // Abort while index 5 is presented with ready high.
    pulse_start0();
    cyc = 0;
    while (!(out_valid0 && out_index0 == 5'd5) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach_idx5", out_index0, 32'd5);
    abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_valid", 32'(out_valid0), 32'd0);
    check("abort_done", 32'(done0), 32'd0);
    check("abort_checksum", checksum0, 32'd30);
    check("abort_regno", reg_no0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_checksum_hold", checksum0, 32'd30);
    check("abort_stays_idle", 32'(busy0), 32'd0);

    // Second start mid-dump is ignored.
    pulse_start0();
    cyc = 0;
    while (!done0 && cyc < 200) begin
      start0 = (cyc == 20);
      @(posedge clk); #1;
      cyc++;
    end
    start0 = 1'b0;
    check("busy_start_done", 32'(done0), 32'd1);
    check("busy_start_cycles", cyc, 32'd64);
    check("busy_start_checksum", checksum0, 32'd1488);
    verify_words0(0, 31);

    // Reset during SETTLE, then a clean dump.
    @(posedge clk); #1;
    pulse_start0();
    cyc = 0;
    while (reg_no0 != 5'd3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rstmid_busy_before", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_regno", reg_no0, 32'd0);
    check("rstmid_valid", 32'(out_valid0), 32'd0);
    check("rstmid_data", out_data0, 32'd0);
    check("rstmid_index", out_index0, 32'd0);
    check("rstmid_last", 32'(out_last0), 32'd0);
    check("rstmid_busy", 32'(busy0), 32'd0);
    check("rstmid_done", 32'(done0), 32'd0);
    check("rstmid_checksum", checksum0, 32'd0);
    @(posedge clk); #1;
    run_dump0(1'b0, 200, cyc);
    check("rstmid_redump_cycles", cyc, 32'd64);
    check("rstmid_redump_checksum", checksum0, 32'd1488);

    // Randomized register contents and random backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 32; n++) rf[n] = $urandom;
      @(posedge clk); #1;
      run_dump0(1'b1, 2000, cyc);
      check("rand_checksum", checksum0, model_sum(0, 31));
      verify_words0(0, 31);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
